// File: rtl/dsp_mac_pipe.sv
// -----------------------------------------------------------------------------
// dsp_mac_pipe -- pipelined unsigned multiply-accumulate unit.
//
// One operation can be issued every cycle. Each operation computes one of
// A*B+C, A*B+P, A*B+(P>>WORD_WIDTH), C, P or 0 into the accumulator P. The
// result appears LATENCY = 1+ABREG+MREG cycles after issue.
//
// Parameters:
//   WORD_WIDTH : operand width of A_i / B_i (1-24)
//   ABREG      : operand input register stages (0-2)
//   MREG       : multiplier output register stages (0-1)
//   GUARD_BITS : extra accumulator MSBs; ACC_WIDTH = 2*WORD_WIDTH+GUARD_BITS
//
// Ports:
//   clock_i  : single clock
//   reset_i  : synchronous active-high reset; flushes everything in flight
//   valid_i  : operation issue strobe
//   op_i     : operation code (000 MUL_C, 001 MUL_ACC, 010 MUL_SHACC,
//              011 LOAD_C, 100 HOLD, 101-111 CLR)
//   A_i, B_i : unsigned multiplicand / multiplier
//   C_i      : unsigned addend (ACC_WIDTH bits)
//   valid_o  : P_o was written by a completed operation this cycle
//   P_o      : accumulator register
//   ovf_o    : (only with DSP_MAC_PIPE_OVF_EN) sticky carry-out flag, cleared
//              by reset or a CLR operation
//
// Build option: define DSP_MAC_PIPE_OVF_EN to add the ovf_o port and the
// overflow detection. Without it, results wrap silently.
// -----------------------------------------------------------------------------
module dsp_mac_pipe #(
   parameter int WORD_WIDTH = 23,
   parameter int ABREG      = 1,
   parameter int MREG       = 1,
   parameter int GUARD_BITS = 0,
   localparam int ACC_WIDTH = 2*WORD_WIDTH+GUARD_BITS
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic                  valid_i,
   input  logic [2:0]            op_i,
   input  logic [WORD_WIDTH-1:0] A_i,
   input  logic [WORD_WIDTH-1:0] B_i,
   input  logic [ACC_WIDTH-1:0]  C_i,
   output logic                  valid_o,
   output logic [ACC_WIDTH-1:0]  P_o
`ifdef DSP_MAC_PIPE_OVF_EN
   ,
   output logic                  ovf_o
`endif
);

   localparam int PROD_WIDTH = 2*WORD_WIDTH;
   // Control/addend travel through the same number of stages as the operands
   // plus the multiplier register, so they meet the product at the add stage.
   localparam int DEPTH      = ABREG+MREG;
`ifdef DSP_MAC_PIPE_OVF_EN
   // One extra bit keeps the carry-out of the add stage for overflow detection.
   localparam int SUM_WIDTH  = ACC_WIDTH+1;
`else
   localparam int SUM_WIDTH  = ACC_WIDTH;
`endif

   localparam logic [2:0] OP_MUL_C     = 3'b000;
   localparam logic [2:0] OP_MUL_ACC   = 3'b001;
   localparam logic [2:0] OP_MUL_SHACC = 3'b010;
   localparam logic [2:0] OP_LOAD_C    = 3'b011;
   localparam logic [2:0] OP_HOLD      = 3'b100;

   logic [WORD_WIDTH-1:0] a_d_s;
   logic [WORD_WIDTH-1:0] b_d_s;
   logic [PROD_WIDTH-1:0] prod_s;
   logic [PROD_WIDTH-1:0] prod_q_s;
   logic                  vld_d_s;
   logic [2:0]            op_d_s;
   logic [ACC_WIDTH-1:0]  c_d_s;
   logic [SUM_WIDTH-1:0]  sum_s;
   logic [ACC_WIDTH-1:0]  p_r;
   logic                  valid_r;

   // ---------------------------------------------------------------- operands
   generate
      if (ABREG == 0) begin : g_ab_bypass
         assign a_d_s = A_i;
         assign b_d_s = B_i;
      end else begin : g_ab_reg
         logic [WORD_WIDTH-1:0] a_r [ABREG];
         logic [WORD_WIDTH-1:0] b_r [ABREG];

         // Operand delay line feeding the multiplier.
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               for (int i = 0; i < ABREG; i++) begin
                  a_r[i] <= '0;
                  b_r[i] <= '0;
               end
            end else begin
               a_r[0] <= A_i;
               b_r[0] <= B_i;
               for (int i = 1; i < ABREG; i++) begin
                  a_r[i] <= a_r[i-1];
                  b_r[i] <= b_r[i-1];
               end
            end
         end

         assign a_d_s = a_r[ABREG-1];
         assign b_d_s = b_r[ABREG-1];
      end
   endgenerate

   // -------------------------------------------------------------- multiplier
   // Full-width unsigned product of the delayed operands.
   always_comb begin
      prod_s = PROD_WIDTH'(a_d_s) * PROD_WIDTH'(b_d_s);
   end

   generate
      if (MREG == 0) begin : g_m_bypass
         assign prod_q_s = prod_s;
      end else begin : g_m_reg
         logic [PROD_WIDTH-1:0] prod_r;

         // Multiplier output register.
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               prod_r <= '0;
            end else begin
               prod_r <= prod_s;
            end
         end

         assign prod_q_s = prod_r;
      end
   endgenerate

   // --------------------------------------------------- control / addend line
   generate
      if (DEPTH == 0) begin : g_ctl_bypass
         assign vld_d_s = valid_i;
         assign op_d_s  = op_i;
         assign c_d_s   = C_i;
      end else begin : g_ctl_reg
         logic                 vld_r [DEPTH];
         logic [2:0]           op_r  [DEPTH];
         logic [ACC_WIDTH-1:0] c_r   [DEPTH];

         // Valid/op/addend delay line; reset drops every in-flight valid so
         // nothing issued before reset can complete afterwards.
         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               for (int i = 0; i < DEPTH; i++) begin
                  vld_r[i] <= 1'b0;
                  op_r[i]  <= 3'b000;
                  c_r[i]   <= '0;
               end
            end else begin
               vld_r[0] <= valid_i;
               op_r[0]  <= op_i;
               c_r[0]   <= C_i;
               for (int i = 1; i < DEPTH; i++) begin
                  vld_r[i] <= vld_r[i-1];
                  op_r[i]  <= op_r[i-1];
                  c_r[i]   <= c_r[i-1];
               end
            end
         end

         assign vld_d_s = vld_r[DEPTH-1];
         assign op_d_s  = op_r[DEPTH-1];
         assign c_d_s   = c_r[DEPTH-1];
      end
   endgenerate

   // --------------------------------------------------------------- add stage
   // Operation decode; Pold is the P register itself so dependent operations
   // in consecutive cycles chain without forwarding.
   always_comb begin
      sum_s = '0;
      case (op_d_s)
         OP_MUL_C:     sum_s = SUM_WIDTH'(prod_q_s) + SUM_WIDTH'(c_d_s);
         OP_MUL_ACC:   sum_s = SUM_WIDTH'(prod_q_s) + SUM_WIDTH'(p_r);
         OP_MUL_SHACC: sum_s = SUM_WIDTH'(prod_q_s) + SUM_WIDTH'(p_r >> WORD_WIDTH);
         OP_LOAD_C:    sum_s = SUM_WIDTH'(c_d_s);
         OP_HOLD:      sum_s = SUM_WIDTH'(p_r);
         default:      sum_s = '0;
      endcase
   end

   // Accumulator and output valid; bubbles hold P and drop valid.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         p_r     <= '0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= vld_d_s;
         if (vld_d_s) begin
            p_r <= sum_s[ACC_WIDTH-1:0];
         end else begin
            p_r <= p_r;
         end
      end
   end

   assign P_o     = p_r;
   assign valid_o = valid_r;

`ifdef DSP_MAC_PIPE_OVF_EN
   logic ovf_r;

   // Sticky overflow: set on carry-out of any completed operation, cleared
   // only by reset or CLR (op codes 101-111).
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ovf_r <= 1'b0;
      end else if (vld_d_s && (op_d_s >= 3'b101)) begin
         ovf_r <= 1'b0;
      end else if (vld_d_s && sum_s[ACC_WIDTH]) begin
         ovf_r <= 1'b1;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf_o = ovf_r;
`endif

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_dsp_mac_pipe -- directed self-checking bench for dsp_mac_pipe with the
// default parameters (WORD_WIDTH=23, ABREG=1, MREG=1, GUARD_BITS=0, so
// ACC_WIDTH=46 and LATENCY=3). Cycle n is the interval just after rising
// edge n; inputs are driven and outputs sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_dsp_mac_pipe;

   localparam int W  = 23;
   localparam int AW = 46;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          valid_i;
   logic [2:0]    op_i;
   logic [W-1:0]  A_i;
   logic [W-1:0]  B_i;
   logic [AW-1:0] C_i;
   logic          valid_o;
   logic [AW-1:0] P_o;
`ifdef DSP_MAC_PIPE_OVF_EN
   logic          ovf_o;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   dsp_mac_pipe dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .op_i    (op_i),
      .A_i     (A_i),
      .B_i     (B_i),
      .C_i     (C_i),
      .valid_o (valid_o),
`ifdef DSP_MAC_PIPE_OVF_EN
      .ovf_o   (ovf_o),
`endif
      .P_o     (P_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic issue(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [AW-1:0] c);
      valid_i = v;
      op_i    = op;
      A_i     = a;
      B_i     = b;
      C_i     = c;
   endtask

   task automatic idle();
      issue(1'b0, 3'b000, 23'd0, 23'd0, 46'd0);
   endtask

   task automatic test_reset();
      idle();
      reset_i = 1'b1;
      step();
      step();
      n_cmp += 1;
      if (valid_o !== 1'b0) begin
         n_mis += 1;
         $display("FAIL reset_valid: got %0b want 0", valid_o);
      end
      n_cmp += 1;
      if (P_o !== 46'd0) begin
         n_mis += 1;
         $display("FAIL reset_p: got %0h want 0", P_o);
      end
`ifdef DSP_MAC_PIPE_OVF_EN
      n_cmp += 1;
      if (ovf_o !== 1'b0) begin
         n_mis += 1;
         $display("FAIL reset_ovf: got %0b want 0", ovf_o);
      end
`endif
      reset_i = 1'b0;
   endtask

   // MUL_C 3*5+7 issued in cycle 0 -> 22 with valid in cycle 3, valid low in 4.
   task automatic test_mul_c();
      issue(1'b1, 3'b000, 23'd3, 23'd5, 46'd7);
      step();
      idle();
      step();
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'd22) begin
         n_mis += 1;
         $display("FAIL mul_c_c3: got valid=%0b P=%0d want valid=1 P=22", valid_o, P_o);
      end
      step();
      n_cmp += 1;
      if (valid_o !== 1'b0 || P_o !== 46'd22) begin
         n_mis += 1;
         $display("FAIL mul_c_c4: got valid=%0b P=%0d want valid=0 P=22", valid_o, P_o);
      end
   endtask

   // Five bubbles hold P=22, then MUL_ACC 1*1 gives 23.
   task automatic test_bubbles();
      for (int i = 0; i < 5; i++) begin
         idle();
         n_cmp += 1;
         if (valid_o !== 1'b0 || P_o !== 46'd22) begin
            n_mis += 1;
            $display("FAIL bubble_%0d: got valid=%0b P=%0d want valid=0 P=22", i, valid_o, P_o);
         end
         step();
      end
      issue(1'b1, 3'b001, 23'd1, 23'd1, 46'd0);
      step();
      idle();
      step();
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'd23) begin
         n_mis += 1;
         $display("FAIL bubble_acc: got valid=%0b P=%0d want valid=1 P=23", valid_o, P_o);
      end
      step();
      step();
      step();
   endtask

   // LOAD_C 10, MUL_ACC 2*4, MUL_ACC 1*1 back to back -> 10, 18, 19.
   task automatic test_accumulate();
      logic [AW-1:0] exp_p [3];
      exp_p[0] = 46'd10;
      exp_p[1] = 46'd18;
      exp_p[2] = 46'd19;
      issue(1'b1, 3'b011, 23'd0, 23'd0, 46'd10);
      step();
      issue(1'b1, 3'b001, 23'd2, 23'd4, 46'd999);
      step();
      issue(1'b1, 3'b001, 23'd1, 23'd1, 46'd999);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         n_cmp += 1;
         if (valid_o !== 1'b1 || P_o !== exp_p[i]) begin
            n_mis += 1;
            $display("FAIL accumulate_%0d: got valid=%0b P=%0d want valid=1 P=%0d",
                     i, valid_o, P_o, exp_p[i]);
         end
         step();
      end
      n_cmp += 1;
      if (valid_o !== 1'b0) begin
         n_mis += 1;
         $display("FAIL accumulate_end: got valid=%0b want 0", valid_o);
      end
      step();
      step();
   endtask

   // LOAD_C 0x800005 then MUL_SHACC 1*1 -> (0x800005>>23)+1 = 2.
   task automatic test_shacc();
      issue(1'b1, 3'b011, 23'd0, 23'd0, 46'h800005);
      step();
      issue(1'b1, 3'b010, 23'd1, 23'd1, 46'd0);
      step();
      idle();
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'h800005) begin
         n_mis += 1;
         $display("FAIL shacc_load: got valid=%0b P=%0h want valid=1 P=800005", valid_o, P_o);
      end
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'd2) begin
         n_mis += 1;
         $display("FAIL shacc: got valid=%0b P=%0h want valid=1 P=2", valid_o, P_o);
      end
      step();
      step();
   endtask

   // Max operands wrap to 0x3FFFFF000000 (carry out), then CLR -> 0.
   task automatic test_wrap();
      issue(1'b1, 3'b000, 23'h7FFFFF, 23'h7FFFFF, 46'h3FFFFFFFFFFF);
      step();
      issue(1'b1, 3'b101, 23'd0, 23'd0, 46'd0);
      step();
      idle();
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'h3FFFFF000000) begin
         n_mis += 1;
         $display("FAIL wrap: got valid=%0b P=%0h want valid=1 P=3fffff000000", valid_o, P_o);
      end
`ifdef DSP_MAC_PIPE_OVF_EN
      n_cmp += 1;
      if (ovf_o !== 1'b1) begin
         n_mis += 1;
         $display("FAIL wrap_ovf: got %0b want 1", ovf_o);
      end
`endif
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'd0) begin
         n_mis += 1;
         $display("FAIL wrap_clr: got valid=%0b P=%0h want valid=1 P=0", valid_o, P_o);
      end
`ifdef DSP_MAC_PIPE_OVF_EN
      n_cmp += 1;
      if (ovf_o !== 1'b0) begin
         n_mis += 1;
         $display("FAIL wrap_clr_ovf: got %0b want 0", ovf_o);
      end
`endif
      step();
      step();
   endtask

   // HOLD and every CLR code complete with valid_o like any other operation.
   task automatic test_hold_clr();
      logic [2:0]    ops   [5];
      logic [AW-1:0] cs    [5];
      logic [AW-1:0] exp_p [5];
      ops[0] = 3'b011; cs[0] = 46'h1234; exp_p[0] = 46'h1234;
      ops[1] = 3'b100; cs[1] = 46'h7777; exp_p[1] = 46'h1234;
      ops[2] = 3'b110; cs[2] = 46'h7777; exp_p[2] = 46'd0;
      ops[3] = 3'b011; cs[3] = 46'd5;    exp_p[3] = 46'd5;
      ops[4] = 3'b111; cs[4] = 46'h7777; exp_p[4] = 46'd0;
      for (int i = 0; i < 8; i++) begin
         if (i < 5) begin
            issue(1'b1, ops[i], 23'd9, 23'd9, cs[i]);
         end else begin
            idle();
         end
         if (i >= 3) begin
            n_cmp += 1;
            if (valid_o !== 1'b1 || P_o !== exp_p[i-3]) begin
               n_mis += 1;
               $display("FAIL hold_clr_%0d: got valid=%0b P=%0h want valid=1 P=%0h",
                        i-3, valid_o, P_o, exp_p[i-3]);
            end
         end
         step();
      end
      step();
      step();
   endtask

   // Reset in cycle 1 discards the MUL_C issued in cycle 0.
   task automatic test_reset_midflight();
      issue(1'b1, 3'b000, 23'd3, 23'd5, 46'd7);
      step();
      idle();
      reset_i = 1'b1;
      n_cmp += 1;
      if (valid_o !== 1'b0) begin
         n_mis += 1;
         $display("FAIL midflight_c1: got valid=%0b want 0", valid_o);
      end
      step();
      reset_i = 1'b0;
      for (int c = 2; c <= 6; c++) begin
         n_cmp += 1;
         if (valid_o !== 1'b0 || P_o !== 46'd0) begin
            n_mis += 1;
            $display("FAIL midflight_c%0d: got valid=%0b P=%0d want valid=0 P=0", c, valid_o, P_o);
         end
         step();
      end
   endtask

   // An operation issued in the first cycle after reset falls completes.
   task automatic test_reset_release();
      idle();
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      issue(1'b1, 3'b000, 23'd3, 23'd5, 46'd7);
      step();
      idle();
      step();
      step();
      n_cmp += 1;
      if (valid_o !== 1'b1 || P_o !== 46'd22) begin
         n_mis += 1;
         $display("FAIL release: got valid=%0b P=%0d want valid=1 P=22", valid_o, P_o);
      end
      step();
      step();
   endtask

   initial begin
      reset_i = 1'b1;
      idle();
      test_reset();
      test_mul_c();
      test_bubbles();
      test_accumulate();
      test_shacc();
      test_wrap();
      test_hold_clr();
      test_reset_midflight();
      test_reset_release();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 23: operand width of A_i and B_i (1-24).
REQ-002 SHALL have parameter ABREG, default 1: operand input register stages (0-2).
REQ-003 SHALL have parameter MREG, default 1: multiplier output register stages (0-1).
REQ-004 SHALL have parameter GUARD_BITS, default 0: extra accumulator MSBs; ACC_WIDTH = 2*WORD_WIDTH+GUARD_BITS, at most 58.
REQ-005 SHALL have port clock_i, input, 1: single clock.
REQ-006 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port valid_i, input, 1: operation issue strobe.
REQ-008 SHALL have port op_i, input, 3: operation code.
REQ-009 SHALL have port A_i, input, WORD_WIDTH: unsigned multiplicand.
REQ-010 SHALL have port B_i, input, WORD_WIDTH: unsigned multiplier.
REQ-011 SHALL have port C_i, input, ACC_WIDTH: unsigned addend.
REQ-012 SHALL have port valid_o, output, 1: P_o updated by a completed operation this cycle.
REQ-013 SHALL have port P_o, output, ACC_WIDTH: accumulator register.

Function
REQ-014 SHALL sample valid_i, op_i, A_i, B_i and C_i together; C_i and op_i are delayed internally to align with the product.
REQ-015 SHALL set LATENCY = 1+ABREG+MREG: an operation issued in cycle t updates P_o and asserts valid_o in cycle t+LATENCY.
REQ-016 SHALL accept one operation per cycle with no stall; there is no backpressure.
REQ-017 SHALL decode op at the add stage (Pold = current P_o):
- 000 MUL_C: A*B+C.
- 001 MUL_ACC: A*B+Pold.
- 010 MUL_SHACC: A*B+(Pold>>WORD_WIDTH), logical shift.
- 011 LOAD_C: C.
- 100 HOLD: Pold.
- 101-111 CLR: 0.
REQ-018 SHALL take Pold from the P register itself, so back-to-back MUL_ACC/MUL_SHACC in consecutive cycles chain correctly.
REQ-019 SHALL compute all arithmetic unsigned and truncate results modulo 2^ACC_WIDTH (wrap-around).
REQ-020 SHALL hold P_o and deassert valid_o in cycles where no valid operation reaches the add stage (bubbles).
REQ-021 SHALL assert valid_o for HOLD and CLR operations like any other operation.

Reset
REQ-022 SHALL, while reset_i is high at a clock edge, clear P_o to 0, valid_o to 0 and all internal valid flags.
REQ-023 SHALL discard operations in flight when reset is asserted mid-pipeline; none of them may produce valid_o after reset deasserts.
REQ-024 SHALL accept a new operation in the first cycle after reset_i falls.

Configuration
REQ-025 SHALL, with DSP_MAC_PIPE_OVF_EN defined, add output ovf_o (1 bit, reset 0): a sticky flag set when any add-stage result before truncation needs more than ACC_WIDTH bits, and cleared only by reset_i or a CLR operation.
REQ-026 SHALL, without DSP_MAC_PIPE_OVF_EN, have no ovf_o port, no overflow logic, and silent wrap-around.

Verification (WORD_WIDTH=23, ABREG=1, MREG=1, GUARD_BITS=0, LATENCY=3)
REQ-027 SHALL cover basic multiply-add: issue MUL_C with A=3, B=5, C=7 at cycle 0 -> valid_o=1 and P_o=22 at cycle 3, valid_o=0 at cycle 4.
REQ-028 SHALL cover accumulation: issue LOAD_C C=10, then MUL_ACC A=2 B=4, then MUL_ACC A=1 B=1 in consecutive cycles -> P_o is 10, 18, 19 on three consecutive valid cycles.
REQ-029 SHALL cover shift-accumulate: LOAD_C C=0x800005, then MUL_SHACC A=1 B=1 -> P_o=2.
REQ-030 SHALL cover wrap and overflow: MUL_C with A=B=0x7FFFFF, C=0x3FFFFFFFFFFF -> P_o=0x3FFFFF000000; ovf_o=1 with the macro defined; a following CLR -> P_o=0, ovf_o=0.
REQ-031 SHALL cover reset mid-flight: issue MUL_C A=3 B=5 C=7 at cycle 0, reset_i high in cycle 1 only -> valid_o stays 0 through cycle 6 and P_o=0.
REQ-032 SHALL cover bubbles: after P_o=22, drive valid_i=0 for 5 cycles, then MUL_ACC A=1 B=1 -> P_o stays 22 with valid_o=0 during the bubbles, then P_o=23 with valid_o=1.
